// File: rtl/disp_pkg.sv
// Shared constants for the score display scheduler: segment glyphs, event codes, states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package disp_pkg;

    // Seven-segment glyphs, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_G     = 7'b0111101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scoring event codes; 6 and 7 are accepted but carry no banner
    localparam logic [2:0] EVT_P1_POINT = 3'd0;
    localparam logic [2:0] EVT_P2_POINT = 3'd1;
    localparam logic [2:0] EVT_P1_GAME  = 3'd2;
    localparam logic [2:0] EVT_P2_GAME  = 3'd3;
    localparam logic [2:0] EVT_P1_MATCH = 3'd4;
    localparam logic [2:0] EVT_P2_MATCH = 3'd5;

    // Scheduler states
    localparam logic [1:0] ST_LIVE = 2'd0;
    localparam logic [1:0] ST_MSG  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_LOCK = 2'd3;

    // Banners use digits 6 and 5 only
    localparam logic [7:0] BANNER_AN = 8'b0110_0000;

    // Two-character banner frame: letter on digit 6, player number on digit 5.
    // Game codes show G, point and match codes show P; odd codes belong to P2.
    function automatic logic [55:0] banner_seg(input logic [2:0] code);
        logic [6:0] letter;
        logic [6:0] digit;
        letter = (code == EVT_P1_GAME || code == EVT_P2_GAME) ? SEG_G : SEG_P;
        digit  = code[0] ? SEG_2 : SEG_1;
        return {SEG_BLANK, letter, digit, 35'h0};
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO with a synchronous clear that dominates push and pop.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: push is ignored while full, pop is ignored while empty.
module evt_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat  = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; clear wins over any simultaneous push or pop
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/score_display_sched.sv
// Chooses the live score frame or queued scoring banners for the 8-digit display.
// Latency: all outputs registered; live frame reaches the outputs 1 cycle later.
// Backpressure: evt_ready drops while the event queue is full (never in LOCK).
module score_display_sched
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int GAP_CYCLES   = 10_000_000,
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  live_an,
    input  logic [55:0] live_seg,
    input  logic        evt_valid,
    input  logic [2:0]  evt_code,
    output logic        evt_ready,
    input  logic        new_match,
    output logic [7:0]  an_out,
    output logic [55:0] seg_out,
    output logic        busy
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES)
                           ? ((HOLD_CYCLES > BLINK_CYCLES) ? HOLD_CYCLES : BLINK_CYCLES)
                           : ((GAP_CYCLES  > BLINK_CYCLES) ? GAP_CYCLES  : BLINK_CYCLES);
    localparam int CW = $clog2(MAX_CYC + 1);

    logic [1:0]    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          blink_q, blink_nxt;
    logic [2:0]    code_q, code_nxt;
    logic          rdy_en_q;
    logic [7:0]    an_nxt;
    logic [55:0]   seg_nxt;

    logic          fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [2:0]    fifo_head;

    // Ready is held off for the first cycle out of reset; in LOCK events are swallowed
    assign evt_ready = rdy_en_q && (state_q == ST_LOCK || !fifo_full);
    assign fifo_push = evt_valid && evt_ready && (state_q != ST_LOCK) && !new_match;
    assign busy      = (state_q != ST_LIVE);

    evt_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (fifo_clr),
        .push   (fifo_push),
        .wr_dat (evt_code),
        .pop    (fifo_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Scheduler: one shared down-counter times MSG, GAP and each blink half-period
    always_comb begin
        logic dispatch;
        dispatch  = 1'b0;
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        blink_nxt = blink_q;
        code_nxt  = code_q;
        fifo_pop  = 1'b0;
        fifo_clr  = 1'b0;
        if (new_match) begin
            state_nxt = ST_LIVE;
            cnt_nxt   = '0;
            blink_nxt = 1'b0;
            fifo_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_LIVE: dispatch = !fifo_empty;
                ST_MSG: begin
                    if (cnt_q == '0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = CW'(GAP_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_nxt = ST_LIVE;
                        dispatch  = !fifo_empty;
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        blink_nxt = !blink_q;
                        cnt_nxt   = CW'(BLINK_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end
            endcase
            // Pop the head and decide: banner, match lock, or silently drop codes 6/7
            if (dispatch) begin
                fifo_pop = 1'b1;
                code_nxt = fifo_head;
                if (fifo_head <= EVT_P2_GAME) begin
                    state_nxt = ST_MSG;
                    cnt_nxt   = CW'(HOLD_CYCLES - 1);
                end else if (fifo_head <= EVT_P2_MATCH) begin
                    state_nxt = ST_LOCK;
                    cnt_nxt   = CW'(BLINK_CYCLES - 1);
                    blink_nxt = 1'b1;
                    fifo_clr  = 1'b1;
                end else begin
                    state_nxt = ST_LIVE;
                    cnt_nxt   = '0;
                end
            end
        end
    end

    // Output frame for the state being entered, so banners appear on the entry edge
    always_comb begin
        an_nxt  = 8'h00;
        seg_nxt = 56'h0;
        case (state_nxt)
            ST_LIVE: begin
                an_nxt  = live_an;
                seg_nxt = live_seg;
            end
            ST_MSG: begin
                an_nxt  = BANNER_AN;
                seg_nxt = banner_seg(code_nxt);
            end
            ST_LOCK: begin
                an_nxt  = blink_nxt ? BANNER_AN : 8'h00;
                seg_nxt = banner_seg(code_nxt);
            end
            default: begin
                an_nxt  = 8'h00;
                seg_nxt = 56'h0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_LIVE;
            cnt_q    <= '0;
            blink_q  <= 1'b0;
            code_q   <= 3'd0;
            rdy_en_q <= 1'b0;
            an_out   <= 8'h00;
            seg_out  <= 56'h0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            blink_q  <= blink_nxt;
            code_q   <= code_nxt;
            rdy_en_q <= 1'b1;
            an_out   <= an_nxt;
            seg_out  <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_score_display_sched.sv
// Randomized bench for score_display_sched against a timeline-based reference model.
// Latency: model predicts registered outputs one edge after each input set.
// Backpressure: model predicts evt_ready from its own queue occupancy and lock state.
module tb_score_display_sched;

    localparam int HOLD  = 8;
    localparam int GAP   = 3;
    localparam int BLINK = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  live_an;
    logic [55:0] live_seg;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic        evt_ready;
    logic        new_match;
    logic [7:0]  an_out;
    logic [55:0] seg_out;
    logic        busy;

    score_display_sched #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP),
        .BLINK_CYCLES (BLINK),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .live_an   (live_an),
        .live_seg  (live_seg),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .new_match (new_match),
        .an_out    (an_out),
        .seg_out   (seg_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending events plus the start times of the current banner / lock
    int          q[$];
    int          m_cyc       = 0;
    bit          m_in_msg    = 1'b0;
    int          m_msg_start = 0;
    bit          m_locked    = 1'b0;
    int          m_lock_start = 0;
    int          m_code      = 0;
    bit          m_rdy_en    = 1'b0;
    logic [7:0]  m_an        = 8'h00;
    logic [55:0] m_seg       = 56'h0;
    bit          m_busy      = 1'b0;
    bit          started     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [55:0] exp_banner(input int c);
        logic [6:0] l;
        logic [6:0] d;
        l = (c == 2 || c == 3) ? 7'b0111101 : 7'b1110011;
        d = (c % 2 == 1) ? 7'b1011011 : 7'b0000110;
        return {7'b0, l, d, 35'b0};
    endfunction

    // Advance the model by one clock edge given the inputs present at that edge
    task automatic model_edge(input bit rdy_pre, input bit v, input logic [2:0] c, input bit r,
                              input bit nm, input logic [7:0] lan, input logic [55:0] lseg);
        int  e;
        int  p;
        bit  push;
        m_cyc++;
        if (!r) begin
            q.delete();
            m_in_msg = 1'b0;
            m_locked = 1'b0;
            m_rdy_en = 1'b0;
            m_an     = 8'h00;
            m_seg    = 56'h0;
            m_busy   = 1'b0;
        end else begin
            m_rdy_en = 1'b1;
            if (nm) begin
                q.delete();
                m_in_msg = 1'b0;
                m_locked = 1'b0;
                m_an     = lan;
                m_seg    = lseg;
                m_busy   = 1'b0;
            end else if (m_locked) begin
                e      = m_cyc - m_lock_start;
                m_an   = ((e / BLINK) % 2 == 0) ? 8'h60 : 8'h00;
                m_seg  = exp_banner(m_code);
                m_busy = 1'b1;
            end else begin
                push = v && rdy_pre;
                if (m_in_msg && (m_cyc - m_msg_start) < HOLD + GAP) begin
                    m_busy = 1'b1;
                    if ((m_cyc - m_msg_start) < HOLD) begin
                        m_an  = 8'h60;
                        m_seg = exp_banner(m_code);
                    end else begin
                        m_an  = 8'h00;
                        m_seg = 56'h0;
                    end
                end else begin
                    m_in_msg = 1'b0;
                    m_an     = lan;
                    m_seg    = lseg;
                    m_busy   = 1'b0;
                    if (q.size() > 0) begin
                        p = q.pop_front();
                        if (p < 4) begin
                            m_in_msg    = 1'b1;
                            m_msg_start = m_cyc;
                            m_code      = p;
                            m_an        = 8'h60;
                            m_seg       = exp_banner(p);
                            m_busy      = 1'b1;
                        end else if (p < 6) begin
                            m_locked     = 1'b1;
                            m_lock_start = m_cyc;
                            m_code       = p;
                            q.delete();
                            push         = 1'b0;
                            m_an         = 8'h60;
                            m_seg        = exp_banner(p);
                            m_busy       = 1'b1;
                        end
                    end
                end
                if (push) q.push_back(int'(c));
            end
        end
    endtask

    // One clock: drive inputs, check ready, clock, update model, check registered outputs
    task automatic step(input bit r, input bit nm, input bit v, input logic [2:0] c);
        logic [63:0] t;
        bit          rdy_exp;
        rst       = r;
        new_match = nm;
        evt_valid = v;
        evt_code  = c;
        live_an   = 8'($urandom);
        t         = {$urandom, $urandom};
        live_seg  = t[55:0];
        #1;
        rdy_exp = m_rdy_en && (m_locked || q.size() < DEPTH);
        if (started) chk("evt_ready", {63'b0, evt_ready}, {63'b0, rdy_exp});
        @(posedge clk);
        model_edge(rdy_exp, v, c, r, nm, live_an, live_seg);
        started = 1'b1;
        @(negedge clk);
        chk("an_out", {56'b0, an_out}, {56'b0, m_an});
        chk("seg_out", {8'b0, seg_out}, {8'b0, m_seg});
        chk("busy", {63'b0, busy}, {63'b0, m_busy});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic push_evt(input logic [2:0] c);
        step(1'b1, 1'b0, 1'b1, c);
    endtask

    initial begin
        int          x;
        bit          r;
        bit          nm;
        bit          v;
        logic [2:0]  c;

        // Reset and live pass-through
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0);
        idle(4);

        // Single point banner, then gap, then live
        push_evt(3'd0);
        idle(16);

        // Fill the queue behind a running banner, including a refused push when full
        push_evt(3'd0);
        push_evt(3'd1);
        push_evt(3'd2);
        push_evt(3'd3);
        push_evt(3'd0);
        push_evt(3'd1);
        idle(75);

        // Match lock: blinking, pushes swallowed, new_match returns to live
        push_evt(3'd5);
        idle(12);
        push_evt(3'd2);
        push_evt(3'd0);
        idle(6);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        idle(4);

        // Code 7 produces nothing; new_match mid-banner with a simultaneous push
        push_evt(3'd7);
        idle(4);
        push_evt(3'd0);
        idle(3);
        push_evt(3'd2);
        step(1'b1, 1'b1, 1'b1, 3'd1);
        idle(14);

        // Reset in the middle of a banner
        push_evt(3'd1);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 3'd2);
        step(1'b0, 1'b0, 1'b0, 3'd0);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) != 0);
            nm = m_locked ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 2) == 0);
            x  = $urandom_range(0, 15);
            c  = (x < 12) ? 3'(x % 4) : ((x < 14) ? 3'(4 + x % 2) : 3'(6 + x % 2));
            step(r, nm, v, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
